// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for the ID/EX stage
// Purpose: forwarding-select enum and the registered ID/EX control bundle.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
  } id_ex_ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - operand forwarding source selector
// Purpose: choose the newest producer of one source register.
// Ports: rs_i (registered source index), exmem_* / memwb_* (write-back
//        enables and destinations of the two older stages), sel_o (source).
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic                      exmem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      memwb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  output fwd_sel_e                  sel_o
);

  // EX/MEM is checked first because it holds the younger result; x0 is
  // hard-wired zero and must never pick up a forwarded value.
  always_comb begin
    sel_o = FWD_REG;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use detect
// Purpose: register decoded instruction, forward operands into the ALU,
//          insert bubbles on flush or load-use hazard.
// Ports: clk/rst_n, stall_i/flush_i, id_* decode inputs, exmem_*/memwb_*
//        forwarding sources, SrcA/SrcB/Operation ALU inputs, ex_* stage
//        outputs, load_use_hazard_o upstream hold request.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_mem_read_i,
  input  logic                      id_mem_write_i,
  input  logic                      id_alu_src_i,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic                      exmem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0]     exmem_result_i,
  input  logic                      memwb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0]     memwb_result_i,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid_o,
  output logic                      ex_reg_write_o,
  output logic                      ex_mem_read_o,
  output logic                      ex_mem_write_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_o,
  output logic [DATA_WIDTH-1:0]     ex_store_data_o,
  output logic                      load_use_hazard_o
);

  id_ex_ctrl_t               ctrl_q, ctrl_d;
  logic [OPCODE_LENGTH-1:0]  alu_op_q, alu_op_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;

  fwd_sel_e                  fwd_a_sel, fwd_b_sel;
  logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;

  // A load in EX cannot supply its data until MEM, so a consumer in ID must wait.
  assign load_use_hazard_o = id_valid_i & ctrl_q.valid & ctrl_q.mem_read &
                             (rd_q != '0) &
                             ((rd_q == id_rs1_addr_i) | (rd_q == id_rs2_addr_i));

  always_comb begin
    ctrl_d     = ctrl_q;
    alu_op_d   = alu_op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    // Flush beats stall so a redirect never leaves a wrong-path op held in EX.
    if (flush_i || (!stall_i && load_use_hazard_o)) begin
      ctrl_d     = '0;
      alu_op_d   = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
    end else if (!stall_i) begin
      ctrl_d.valid     = id_valid_i;
      ctrl_d.reg_write = id_reg_write_i;
      ctrl_d.mem_read  = id_mem_read_i;
      ctrl_d.mem_write = id_mem_write_i;
      ctrl_d.alu_src   = id_alu_src_i;
      alu_op_d         = id_alu_op_i;
      rs1_d            = id_rs1_addr_i;
      rs2_d            = id_rs2_addr_i;
      rd_d             = id_rd_addr_i;
      rs1_data_d       = id_rs1_data_i;
      rs2_data_d       = id_rs2_data_i;
      imm_d            = id_imm_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      alu_op_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_op_q   <= alu_op_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i              (rs1_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .sel_o             (fwd_a_sel)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i              (rs2_q),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .sel_o             (fwd_b_sel)
  );

  always_comb begin
    fwd_a = rs1_data_q;
    case (fwd_a_sel)
      FWD_EXMEM: fwd_a = exmem_result_i;
      FWD_MEMWB: fwd_a = memwb_result_i;
      default:   fwd_a = rs1_data_q;
    endcase
    fwd_b = rs2_data_q;
    case (fwd_b_sel)
      FWD_EXMEM: fwd_b = exmem_result_i;
      FWD_MEMWB: fwd_b = memwb_result_i;
      default:   fwd_b = rs2_data_q;
    endcase
  end

  assign SrcA            = fwd_a;
  assign SrcB            = ctrl_q.alu_src ? imm_q : fwd_b;
  assign ex_store_data_o = fwd_b;
  assign Operation       = alu_op_q;
  assign ex_valid_o      = ctrl_q.valid;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_rd_o         = rd_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width.
REQ-002 Parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 Parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 stall_i  input  1  hold all stage registers (downstream stall).
REQ-007 flush_i  input  1  replace incoming instruction with bubble (branch/jump redirect).
REQ-008 id_valid_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_alu_src_i  input  1 each  decode-stage valid and control bits; alu_src=1 selects immediate.
REQ-009 id_alu_op_i  input  OPCODE_LENGTH  decoded ALU operation.
REQ-010 id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  input  REG_ADDR_WIDTH  register indices.
REQ-011 id_rs1_data_i, id_rs2_data_i, id_imm_i  input  DATA_WIDTH  register-file reads, sign-extended immediate.
REQ-012 exmem_reg_write_i  input  1; exmem_rd_i  input  REG_ADDR_WIDTH; exmem_result_i  input  DATA_WIDTH  EX/MEM forwarding source.
REQ-013 memwb_reg_write_i  input  1; memwb_rd_i  input  REG_ADDR_WIDTH; memwb_result_i  input  DATA_WIDTH  MEM/WB forwarding source.
REQ-014 SrcA, SrcB  output  DATA_WIDTH  ALU operands; Operation  output  OPCODE_LENGTH  ALU operation.
REQ-015 ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  output  1 each; ex_rd_o  output  REG_ADDR_WIDTH; ex_store_data_o  output  DATA_WIDTH  forwarded rs2 for stores.
REQ-016 load_use_hazard_o  output  1  request to upstream to hold PC and IF/ID.

Function
REQ-017 Stage register latency SHALL be exactly one cycle from id_* inputs to registered EX fields.
REQ-018 Update priority per rising edge SHALL be: flush_i > stall_i > load-use bubble > normal capture.
REQ-019 Flush SHALL clear valid, reg_write, mem_read, mem_write, rd, alu_op and all data fields to zero, even if stall_i is high.
REQ-020 Stall (no flush) SHALL hold every registered field unchanged.
REQ-021 load_use_hazard_o SHALL be combinational: id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & (ex_rd_o == id_rs1_addr_i | ex_rd_o == id_rs2_addr_i).
REQ-022 When load_use_hazard_o is high and neither flush nor stall, the stage SHALL capture a bubble (as REQ-019); upstream re-presents the instruction next cycle.
REQ-023 Forwarding per operand SHALL select exmem_result_i if exmem_reg_write_i & exmem_rd_i != 0 & exmem_rd_i == registered rs; else memwb_result_i on the same test against MEM/WB; else registered register-file data.
REQ-024 EX/MEM SHALL win when both sources match; index 0 SHALL never be forwarded.
REQ-025 SrcA SHALL be forwarded rs1; SrcB SHALL be registered immediate when registered alu_src=1, else forwarded rs2; ex_store_data_o SHALL always be forwarded rs2.
REQ-026 Forwarding muxes SHALL be purely combinational from registered fields and current forwarding inputs (no added latency).
REQ-027 Operation SHALL equal registered alu_op; bubbles present 4'b0000 with reg_write/mem_* deasserted.

Reset
REQ-028 rst_n low SHALL asynchronously clear all registered fields to zero, giving ex_valid_o=0, controls=0, ex_rd_o=0, Operation=0.
REQ-029 Reset deassertion mid-operation SHALL resume with a bubble in EX; no partial instruction survives reset.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold fwd_sel_e (FWD_REG, FWD_EXMEM, FWD_MEMWB) and the id_ex_ctrl_t control struct.
REQ-031 Sub-module forward_unit (rs index + two sources -> fwd_sel_e) SHALL be instantiated once per operand.

Verification
REQ-032 Reset: rst_n=0 mid-cycle -> all outputs 0 immediately, ex_valid_o=0.
REQ-033 EX/MEM forward: registered rs1=5, exmem_rd=5, reg_write=1, result=0x1234 -> SrcA=0x1234.
REQ-034 Double match: rs2=7 in both EX/MEM (0xAAAA) and MEM/WB (0xBBBB), alu_src=0 -> SrcB=0xAAAA; with rd=0 in both -> SrcB=register data.
REQ-035 Load-use: EX holds lw to x3, ID uses rs1=3 -> load_use_hazard_o=1, next cycle ex_valid_o=0, reg_write=0.
REQ-036 Stall+flush same edge -> bubble captured; stall alone for 3 cycles -> all EX outputs unchanged.
REQ-037 Immediate path: alu_src=1, imm=0xFFFFFFFC, alu_op=4'b0010 -> SrcB=0xFFFFFFFC, Operation=4'b0010 one cycle later.
